pt2272_decoder: RTL and testbench
=================================

// Module: pt2272_decoder
// PURPOSE
//  Receive side of the PT2262/PT2272 remote link: samples the serial waveform on din, measures pulse widths,
//  decodes 12 symbols (8 address trits A0..A7 + 4 data bits D0..D3) per frame and checks the address against the
//  local 16-bit trit code (2 bits/trit: 0=00, 1=11, F=01; trit k in ax_local[2k+1:2k]). Latches data and raises
//  vt after two consecutive identical matching frames. Sits between the RF front-end pin and the application.
// PARAMETERS
//  ALPHA_CYC      4     clk cycles per alpha (oscillator unit); all windows below are multiples of it
//  SYNC_MIN_ALPHA 32    minimum low run, in alpha, recognised as sync gap
//  VT_HOLD_CYC    1000  clk cycles after the last good frame before vt drops
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  din        in   1   raw serial input, asynchronous to clk
//  ax_local   in   16  local address code, encoding above
//  data_out   out  4   last accepted data, D0 in bit 0
//  vt         out  1   valid transmission
//  frame_ok   out  1   1-cycle pulse: well-formed frame, address match
//  frame_err  out  1   1-cycle pulse: framing/timing/code error
// BEHAVIOUR
//  Reset: data_out=0, vt=0, frame_ok=0, frame_err=0, state=HUNT, counters/shift reg=0. All outputs registered.
//  din passes a 2-FF synchroniser; edges detected on the synchronised signal (2-cycle input latency).
//  Width counter: saturating, width $clog2(SYNC_MIN_ALPHA*ALPHA_CYC+1); restarts at 1 on each edge.
//  Pulse = one high phase (hw) + following low phase (lw). Valid iff 12a <= hw+lw <= 20a and hw <= 16a
//  (a = ALPHA_CYC). Pulse bit = (hw > lw). Symbol = 2 pulses: first -> bit [2k+1], second -> bit [2k].
//  States:
//   HUNT   : count low run; when it reaches SYNC_MIN_ALPHA*a -> ARMED. Any high resets count.
//   ARMED  : wait rising edge -> HIGH, pulse index=0. Stays indefinitely while low.
//   HIGH   : count hw; falling edge -> LOW; hw > 16a -> error.
//   LOW    : count lw; rising edge -> classify, shift bit in, index++; index 24 reached -> SYNCH else HIGH.
//            hw+lw > 20a while still low -> error.
//   SYNCH  : sync high; falling edge with hw <= 8a -> SYNCL; hw > 8a -> error.
//   SYNCL  : low run reaches SYNC_MIN_ALPHA*a -> evaluate frame (one cycle), -> ARMED (sync also arms next frame).
//            Rising edge before that -> error.
//  Error: frame_err=1 for one cycle, shift reg/index cleared, -> HUNT. vt and data_out unaffected.
//  Evaluate: any address pair 10 or data pair not in {00,11} -> error. Address != ax_local -> no frame_ok,
//   vt cleared, match history cleared. Else frame_ok=1; if data equals previous good frame's data (previous
//   evaluate was also good, no error between) -> data_out<=data, vt<=1 same cycle. Else data held, vt unchanged.
//  vt timeout: hold counter reloads VT_HOLD_CYC on each frame_ok; vt falls when it expires (exactly
//   VT_HOLD_CYC cycles after last frame_ok). data_out held after vt falls.
//  Reset mid-frame: immediate return to reset values; first frame after reset needs a full sync gap.
// STRUCTURE
//  pt22_pkg: state enum (HUNT,ARMED,HIGH,LOW,SYNCH,SYNCL), CODE_0=2'b00, CODE_1=2'b11, CODE_F=2'b01,
//   N_ADDR=8, N_DATA=4, N_PULSES=24, pulse-window constants in alpha (12,16,20,8).
//  Sub-module pt22_din_sync: 2-FF synchroniser + rise/fall pulse outputs. Rest (FSM, counter, shift reg,
//   compare, vt hold) in this module.
// TESTING (ALPHA_CYC=4: short=16, long=48 cycles, sync = 16 high + 496 low)
//  1 rst_n low with din toggling -> all outputs 0; release, din low 128 cycles -> no pulses, vt=0.
//  2 ax_local=16'h5555 (all F), two frames data 4'b1010 -> frame_ok twice; vt=1, data_out=1010 at 2nd evaluate.
//  3 Single good frame then din low -> one frame_ok, vt stays 0, data_out 0.
//  4 vt=1, then frame with A3=1 (pair 11 vs 01) -> no frame_ok, vt=0 at its evaluate; data_out unchanged.
//  5 Pulse 5 high stretched to 120 cycles -> frame_err once, no vt; next two good frames -> vt=1.
//  6 vt=1, VT_HOLD_CYC=1000, din stops -> vt falls exactly 1000 cycles after last frame_ok; rst_n mid-frame -> reset values.

Source files
------------

// File: rtl/pt22_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pt22_pkg
// Brief    : Shared types, frame constants and trit-code helpers for the
//            PT2272-compatible receive decoder.
// Revision : 1.0
// ============================================================================
package pt22_pkg;

    typedef enum logic [2:0] {
        HUNT  = 3'd0,
        ARMED = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        SYNCH = 3'd4,
        SYNCL = 3'd5
    } pt22_state_e;

    localparam logic [1:0] CODE_0 = 2'b00;
    localparam logic [1:0] CODE_1 = 2'b11;
    localparam logic [1:0] CODE_F = 2'b01;

    localparam int N_ADDR   = 8;
    localparam int N_DATA   = 4;
    localparam int N_SYM    = N_ADDR + N_DATA;
    localparam int N_PULSES = 2 * N_SYM;

    // Pulse timing windows, in units of alpha
    localparam int PULSE_MIN_A     = 12;
    localparam int HIGH_MAX_A      = 16;
    localparam int PULSE_MAX_A     = 20;
    localparam int SYNC_HIGH_MAX_A = 8;

    // Pair 10 is never a legal trit; data symbols may only be 0 or 1.
    function automatic logic frame_code_bad(input logic [N_PULSES-1:0] f);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < N_ADDR; k++) begin
            if (f[2*k +: 2] == 2'b10) bad = 1'b1;
        end
        for (int j = 0; j < N_DATA; j++) begin
            if (f[2*(N_ADDR+j) +: 2] != CODE_0 && f[2*(N_ADDR+j) +: 2] != CODE_1) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [N_DATA-1:0] frame_data(input logic [N_PULSES-1:0] f);
        logic [N_DATA-1:0] d;
        for (int j = 0; j < N_DATA; j++) begin
            d[j] = f[2*(N_ADDR+j)];
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pt22_din_sync.sv
`default_nettype none
// ============================================================================
// Module   : pt22_din_sync
// Brief    : Two-flop synchroniser for the raw RF data pin with edge pulses
//            derived from the synchronised level.
// Revision : 1.0
// ============================================================================
module pt22_din_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign lvl_o  = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/pt2272_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pt2272_decoder
// Brief    : PT2272-style receiver: pulse-width decode of 12 trit/bit symbols,
//            address match, two-frame data confirmation and vt hold timer.
// Revision : 1.0
// ============================================================================
module pt2272_decoder
    import pt22_pkg::*;
#(
    parameter int ALPHA_CYC      = 4,
    parameter int SYNC_MIN_ALPHA = 32,
    parameter int VT_HOLD_CYC    = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    din_i,
    input  logic [2*N_ADDR-1:0]     ax_local_i,
    output logic [N_DATA-1:0]       data_out_o,
    output logic                    vt_o,
    output logic                    frame_ok_o,
    output logic                    frame_err_o
);

    localparam int CW = $clog2(SYNC_MIN_ALPHA*ALPHA_CYC + 1);
    localparam int HW = $clog2(VT_HOLD_CYC + 1);

    localparam logic [CW-1:0] CNT_MAX       = '1;
    localparam logic [CW-1:0] SYNC_LOW_CYC  = CW'(SYNC_MIN_ALPHA*ALPHA_CYC);
    localparam logic [CW:0]   PULSE_MIN     = (CW+1)'(PULSE_MIN_A*ALPHA_CYC);
    localparam logic [CW:0]   PULSE_MAX     = (CW+1)'(PULSE_MAX_A*ALPHA_CYC);
    localparam logic [CW:0]   HIGH_MAX      = (CW+1)'(HIGH_MAX_A*ALPHA_CYC);
    localparam logic [CW:0]   SYNC_HIGH_MAX = (CW+1)'(SYNC_HIGH_MAX_A*ALPHA_CYC);
    localparam logic [HW-1:0] HOLD_LOAD     = HW'(VT_HOLD_CYC);
    localparam logic [4:0]    LAST_IDX      = 5'(N_PULSES-1);

    logic lvl_w, rise_w, fall_w;

    pt22_din_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (din_i),
        .lvl_o  (lvl_w),
        .rise_o (rise_w),
        .fall_o (fall_w)
    );

    pt22_state_e           state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         hw_q, hw_d;
    logic [4:0]            idx_q, idx_d;
    logic [N_PULSES-1:0]   shift_q, shift_d;
    logic [N_DATA-1:0]     data_q, data_d;
    logic                  vt_q, vt_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic                  hist_v_q, hist_v_d;
    logic [N_DATA-1:0]     hist_data_q, hist_data_d;
    logic                  ok_q, ok_d;
    logic                  err_q, err_d;
    logic                  fail_w;

    logic [CW:0]           run_w, done_w, sum_run_w, sum_done_w;
    logic                  bit_w;
    logic [4:0]            wr_idx_w;
    logic [N_DATA-1:0]     fdata_w;
    logic                  code_bad_w;

    // Width of the current level including this cycle; restarts on every edge
    assign cnt_d      = (rise_w | fall_w) ? CW'(1) :
                        (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    assign run_w      = {1'b0, cnt_d};
    assign done_w     = {1'b0, cnt_q};
    assign sum_run_w  = {1'b0, hw_q} + run_w;
    assign sum_done_w = {1'b0, hw_q} + done_w;
    assign bit_w      = (hw_q > cnt_q);
    assign wr_idx_w   = {idx_q[4:1], ~idx_q[0]};
    assign fdata_w    = frame_data(shift_q);
    assign code_bad_w = frame_code_bad(shift_q);

    always_comb begin
        state_d     = state_q;
        hw_d        = hw_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        vt_d        = vt_q;
        hold_d      = hold_q;
        hist_v_d    = hist_v_q;
        hist_data_d = hist_data_q;
        ok_d        = 1'b0;
        err_d       = 1'b0;
        fail_w      = 1'b0;

        if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
            if (hold_q == HW'(1)) vt_d = 1'b0;
        end

        case (state_q)
            HUNT: begin
                if (!lvl_w && cnt_d >= SYNC_LOW_CYC) state_d = ARMED;
            end
            ARMED: begin
                if (rise_w) begin
                    state_d = HIGH;
                    idx_d   = '0;
                end
            end
            HIGH: begin
                if (fall_w) begin
                    hw_d    = cnt_q;
                    state_d = LOW;
                end else if (run_w > HIGH_MAX) begin
                    fail_w = 1'b1;
                end
            end
            LOW: begin
                if (rise_w) begin
                    if (sum_done_w < PULSE_MIN || sum_done_w > PULSE_MAX) begin
                        fail_w = 1'b1;
                    end else begin
                        shift_d[wr_idx_w] = bit_w;
                        idx_d             = idx_q + 5'd1;
                        state_d           = (idx_q == LAST_IDX) ? SYNCH : HIGH;
                    end
                end else if (sum_run_w > PULSE_MAX) begin
                    fail_w = 1'b1;
                end
            end
            SYNCH: begin
                if (fall_w) begin
                    if (done_w > SYNC_HIGH_MAX) fail_w = 1'b1;
                    else                        state_d = SYNCL;
                end else if (run_w > SYNC_HIGH_MAX) begin
                    fail_w = 1'b1;
                end
            end
            SYNCL: begin
                if (rise_w) begin
                    fail_w = 1'b1;
                end else if (cnt_d >= SYNC_LOW_CYC) begin
                    // The sync gap that closes this frame also arms the next one
                    state_d = ARMED;
                    shift_d = '0;
                    idx_d   = '0;
                    if (code_bad_w) begin
                        fail_w = 1'b1;
                    end else if (shift_q[2*N_ADDR-1:0] != ax_local_i) begin
                        vt_d     = 1'b0;
                        hold_d   = '0;
                        hist_v_d = 1'b0;
                    end else begin
                        ok_d   = 1'b1;
                        hold_d = HOLD_LOAD;
                        if (hist_v_q && fdata_w == hist_data_q) begin
                            data_d = fdata_w;
                            vt_d   = 1'b1;
                        end
                        hist_v_d    = 1'b1;
                        hist_data_d = fdata_w;
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        if (fail_w) begin
            err_d    = 1'b1;
            shift_d  = '0;
            idx_d    = '0;
            hist_v_d = 1'b0;
            state_d  = HUNT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            cnt_q       <= '0;
            hw_q        <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            vt_q        <= 1'b0;
            hold_q      <= '0;
            hist_v_q    <= 1'b0;
            hist_data_q <= '0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hw_q        <= hw_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            vt_q        <= vt_d;
            hold_q      <= hold_d;
            hist_v_q    <= hist_v_d;
            hist_data_q <= hist_data_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
        end
    end

    assign data_out_o  = data_q;
    assign vt_o        = vt_q;
    assign frame_ok_o  = ok_q;
    assign frame_err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pt2272_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pt2272_decoder
// Brief    : Directed self-checking bench for pt2272_decoder (ALPHA_CYC=4).
// Revision : 1.0
// ============================================================================
module tb_pt2272_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din_i = 1'b0;
    logic [15:0] ax_local_i = 16'h5555;
    logic [3:0]  data_out_o;
    logic        vt_o;
    logic        frame_ok_o;
    logic        frame_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    pt2272_decoder #(
        .ALPHA_CYC      (4),
        .SYNC_MIN_ALPHA (32),
        .VT_HOLD_CYC    (1000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din_i       (din_i),
        .ax_local_i  (ax_local_i),
        .data_out_o  (data_out_o),
        .vt_o        (vt_o),
        .frame_ok_o  (frame_ok_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk = ~clk;

    // Event monitor: pulse counts and the output snapshot at each frame_ok
    int       cyc = 0;
    int       ok_total = 0;
    int       err_total = 0;
    int       last_ok_cyc = 0;
    int       vt_fall_cyc = 0;
    logic     vt_prev = 1'b0;
    logic     vt_at_ok = 1'b0;
    logic     vt_at_ok_prev = 1'b0;
    logic [3:0] data_at_ok = 4'h0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_ok_o === 1'b1) begin
            ok_total      <= ok_total + 1;
            last_ok_cyc   <= cyc;
            vt_at_ok_prev <= vt_at_ok;
            vt_at_ok      <= vt_o;
            data_at_ok    <= data_out_o;
        end
        if (frame_err_o === 1'b1) err_total <= err_total + 1;
        if (vt_prev === 1'b1 && vt_o === 1'b0) vt_fall_cyc <= cyc;
        vt_prev <= vt_o;
    end

    task automatic drive(input logic v, input int n);
        din_i = v;
        repeat (n) @(negedge clk);
    endtask

    // bit 1 = long high/short low, bit 0 = short high/long low, then sync
    task automatic send_frame(input logic [15:0] addr, input logic [3:0] data,
                              input int stretch_idx, input int stretch_hw);
        logic [1:0] pair;
        logic       b;
        int         hw, lw;
        for (int p = 0; p < 24; p++) begin
            if (p / 2 < 8) pair = addr[2*(p/2) +: 2];
            else           pair = data[p/2 - 8] ? 2'b11 : 2'b00;
            b  = (p % 2 == 0) ? pair[1] : pair[0];
            hw = b ? 48 : 16;
            lw = b ? 16 : 48;
            if (p == stretch_idx) hw = stretch_hw;
            drive(1'b1, hw);
            drive(1'b0, lw);
        end
        drive(1'b1, 16);
        drive(1'b0, 496);
    endtask

    task automatic test_reset;
        int ok0, err0;
        rst_n = 1'b0;
        for (int i = 0; i < 20; i++) drive(i[0], 3);
        n_tests++; if (data_out_o !== 4'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_out_o); end
        n_tests++; if (vt_o !== 1'b0) begin n_fail++; $display("FAIL reset_vt: got %b want 0", vt_o); end
        n_tests++; if (frame_ok_o !== 1'b0) begin n_fail++; $display("FAIL reset_ok: got %b want 0", frame_ok_o); end
        n_tests++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", frame_err_o); end
        din_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ok0 = ok_total; err0 = err_total;
        drive(1'b0, 128);
        n_tests++; if (ok_total - ok0 !== 0) begin n_fail++; $display("FAIL idle_ok: got %0d want 0", ok_total - ok0); end
        n_tests++; if (err_total - err0 !== 0) begin n_fail++; $display("FAIL idle_err: got %0d want 0", err_total - err0); end
        n_tests++; if (vt_o !== 1'b0) begin n_fail++; $display("FAIL idle_vt: got %b want 0", vt_o); end
    endtask

    task automatic test_single_frame;
        int ok0, err0;
        drive(1'b0, 200);
        ok0 = ok_total; err0 = err_total;
        send_frame(16'h5555, 4'b0110, -1, 0);
        drive(1'b0, 1200);
        n_tests++; if (ok_total - ok0 !== 1) begin n_fail++; $display("FAIL single_ok: got %0d want 1", ok_total - ok0); end
        n_tests++; if (err_total - err0 !== 0) begin n_fail++; $display("FAIL single_err: got %0d want 0", err_total - err0); end
        n_tests++; if (vt_o !== 1'b0) begin n_fail++; $display("FAIL single_vt: got %b want 0", vt_o); end
        n_tests++; if (data_out_o !== 4'h0) begin n_fail++; $display("FAIL single_data: got %h want 0", data_out_o); end
    endtask

    task automatic test_two_frames;
        int ok0, err0;
        ok0 = ok_total; err0 = err_total;
        send_frame(16'h5555, 4'b1010, -1, 0);
        send_frame(16'h5555, 4'b1010, -1, 0);
        n_tests++; if (ok_total - ok0 !== 2) begin n_fail++; $display("FAIL pair_ok: got %0d want 2", ok_total - ok0); end
        n_tests++; if (err_total - err0 !== 0) begin n_fail++; $display("FAIL pair_err: got %0d want 0", err_total - err0); end
        n_tests++; if (vt_at_ok_prev !== 1'b0) begin n_fail++; $display("FAIL pair_vt_first: got %b want 0", vt_at_ok_prev); end
        n_tests++; if (vt_at_ok !== 1'b1) begin n_fail++; $display("FAIL pair_vt_second: got %b want 1", vt_at_ok); end
        n_tests++; if (data_at_ok !== 4'b1010) begin n_fail++; $display("FAIL pair_data: got %b want 1010", data_at_ok); end
    endtask

    task automatic test_addr_mismatch;
        int ok0, err0;
        ok0 = ok_total; err0 = err_total;
        send_frame(16'h55D5, 4'b1010, -1, 0);
        n_tests++; if (ok_total - ok0 !== 0) begin n_fail++; $display("FAIL mism_ok: got %0d want 0", ok_total - ok0); end
        n_tests++; if (err_total - err0 !== 0) begin n_fail++; $display("FAIL mism_err: got %0d want 0", err_total - err0); end
        n_tests++; if (vt_o !== 1'b0) begin n_fail++; $display("FAIL mism_vt: got %b want 0", vt_o); end
        n_tests++; if (data_out_o !== 4'b1010) begin n_fail++; $display("FAIL mism_data: got %b want 1010", data_out_o); end
        send_frame(16'h5555, 4'b1010, -1, 0);
        n_tests++; if (ok_total - ok0 !== 1) begin n_fail++; $display("FAIL mism_next_ok: got %0d want 1", ok_total - ok0); end
        n_tests++; if (vt_at_ok !== 1'b0) begin n_fail++; $display("FAIL mism_hist_cleared: vt got %b want 0", vt_at_ok); end
    endtask

    task automatic test_timing_error;
        int ok0, err0;
        ok0 = ok_total; err0 = err_total;
        send_frame(16'h5555, 4'b1010, 5, 120);
        n_tests++; if (err_total - err0 !== 1) begin n_fail++; $display("FAIL stretch_err: got %0d want 1", err_total - err0); end
        n_tests++; if (ok_total - ok0 !== 0) begin n_fail++; $display("FAIL stretch_ok: got %0d want 0", ok_total - ok0); end
        n_tests++; if (vt_o !== 1'b0) begin n_fail++; $display("FAIL stretch_vt: got %b want 0", vt_o); end
        send_frame(16'h5555, 4'b1010, -1, 0);
        send_frame(16'h5555, 4'b1010, -1, 0);
        n_tests++; if (ok_total - ok0 !== 2) begin n_fail++; $display("FAIL recover_ok: got %0d want 2", ok_total - ok0); end
        n_tests++; if (err_total - err0 !== 1) begin n_fail++; $display("FAIL recover_err: got %0d want 1", err_total - err0); end
        n_tests++; if (vt_at_ok_prev !== 1'b0) begin n_fail++; $display("FAIL recover_vt_first: got %b want 0", vt_at_ok_prev); end
        n_tests++; if (vt_o !== 1'b1) begin n_fail++; $display("FAIL recover_vt: got %b want 1", vt_o); end
    endtask

    task automatic test_vt_timeout_and_reset;
        int n, ok0, err0;
        n = 0;
        while (vt_o === 1'b1 && n < 1500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        n_tests++; if (n >= 1500) begin n_fail++; $display("FAIL vt_timeout_wait: vt still %b after %0d cycles", vt_o, n); end
        n_tests++; if (vt_fall_cyc - last_ok_cyc !== 1000) begin n_fail++; $display("FAIL vt_hold_len: got %0d want 1000", vt_fall_cyc - last_ok_cyc); end
        n_tests++; if (data_out_o !== 4'b1010) begin n_fail++; $display("FAIL vt_fall_data: got %b want 1010", data_out_o); end
        // Reset in the middle of a frame's pulses
        drive(1'b1, 48);
        drive(1'b0, 16);
        drive(1'b1, 10);
        rst_n = 1'b0;
        #1;
        n_tests++; if (data_out_o !== 4'h0) begin n_fail++; $display("FAIL midrst_data: got %h want 0", data_out_o); end
        n_tests++; if (vt_o !== 1'b0 || frame_ok_o !== 1'b0 || frame_err_o !== 1'b0) begin
            n_fail++; $display("FAIL midrst_flags: vt=%b ok=%b err=%b want 0", vt_o, frame_ok_o, frame_err_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ok0 = ok_total; err0 = err_total;
        send_frame(16'h5555, 4'b0011, -1, 0);
        n_tests++; if (ok_total - ok0 !== 0) begin n_fail++; $display("FAIL post_rst_nogap_ok: got %0d want 0", ok_total - ok0); end
        send_frame(16'h5555, 4'b0011, -1, 0);
        n_tests++; if (ok_total - ok0 !== 1) begin n_fail++; $display("FAIL post_rst_ok: got %0d want 1", ok_total - ok0); end
        n_tests++; if (err_total - err0 !== 0) begin n_fail++; $display("FAIL post_rst_err: got %0d want 0", err_total - err0); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_two_frames();
        test_addr_mismatch();
        test_timing_error();
        test_vt_timeout_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
